// File: rtl/logic_pll_lock_service_timer_if.sv
// AXI4-Stream interface shared by the lock service blocks.
// rx modport is the sink side, tx modport is the source side.
interface logic_axi4_stream_if #(
   parameter int TDATA_BYTES = 4,
   parameter int TUSER_W     = 1,
   parameter int TDEST_W     = 1,
   parameter int TID_W       = 1
);
   logic                     tvalid;
   logic                     tready;
   logic [8*TDATA_BYTES-1:0] tdata;
   logic [TDATA_BYTES-1:0]   tstrb;
   logic [TDATA_BYTES-1:0]   tkeep;
   logic                     tlast;
   logic [TUSER_W-1:0]       tuser;
   logic [TDEST_W-1:0]       tdest;
   logic [TID_W-1:0]         tid;

   modport rx (input tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid, output tready);
   modport tx (output tvalid, tdata, tstrb, tkeep, tlast, tuser, tdest, tid, input tready);
endinterface

// File: rtl/logic_pll_lock_service_timer.sv
// One-shot countdown timer for the PLL lock service FSM: load N on timer_config,
// expiry event on timer after max(N,1) ticks. Optional: LOGIC_PLL_LOCK_SERVICE_TIMER_PRESCALER_EN.
module logic_pll_lock_service_timer #(
   parameter int TDATA_BYTES = 4,
   parameter int PRESCALER   = 1
) (
   input logic             aclk,
   input logic             areset_n,
   logic_axi4_stream_if.rx timer_config,
   logic_axi4_stream_if.tx timer
);
   localparam int CW = 8*TDATA_BYTES;
   localparam logic [CW-1:0] ONE = CW'(1);

   typedef enum logic [1:0] {IDLE, RUNNING, EXPIRED} state_t;

   state_t        state_q, state_n;
   logic [CW-1:0] cnt_q, cnt_n;
   logic [CW-1:0] data_q, data_n;
   logic          load;
   logic          tick;

   if (PRESCALER < 1) begin : g_drc
      $error("PRESCALER must be >= 1");
   end

   // Always ready, so every valid beat is a load.
   assign timer_config.tready = 1'b1;
   assign load                = timer_config.tvalid;

`ifdef LOGIC_PLL_LOCK_SERVICE_TIMER_PRESCALER_EN
   localparam int PW = (PRESCALER > 1) ? $clog2(PRESCALER) : 1;
   localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALER - 1);

   logic [PW-1:0] pre_q, pre_n;

   assign tick = (pre_q == PRE_MAX);

   always_comb begin
      pre_n = '0;
      if (!load && state_q == RUNNING && !tick)
         pre_n = pre_q + PW'(1);
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) pre_q <= '0;
      else           pre_q <= pre_n;
   end
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      state_n = state_q;
      cnt_n   = cnt_q;
      data_n  = data_q;
      if (load) begin
         // Load wins over everything, including a pending event being accepted.
         state_n = RUNNING;
         cnt_n   = (timer_config.tdata == '0) ? ONE : timer_config.tdata;
         data_n  = timer_config.tdata;
      end else begin
         case (state_q)
            RUNNING: begin
               if (tick) begin
                  if (cnt_q <= ONE) begin
                     state_n = EXPIRED;
                     cnt_n   = '0;
                  end else begin
                     cnt_n = cnt_q - ONE;
                  end
               end
            end
            EXPIRED: if (timer.tready) state_n = IDLE;
            default: ;
         endcase
      end
   end

   always_ff @(posedge aclk or negedge areset_n) begin
      if (!areset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_n;
         cnt_q   <= cnt_n;
         data_q  <= data_n;
      end
   end

   // tvalid comes straight from the state register: no path from tready.
   assign timer.tvalid = (state_q == EXPIRED);
   assign timer.tdata  = data_q;
   assign timer.tlast  = 1'b1;
   assign timer.tstrb  = '1;
   assign timer.tkeep  = '1;
   assign timer.tuser  = '0;
   assign timer.tdest  = '0;
   assign timer.tid    = '0;
endmodule

// File: tb/tb_logic_pll_lock_service_timer.sv
// Directed bench for logic_pll_lock_service_timer: latency table plus corner sequences.
module tb_logic_pll_lock_service_timer;
`ifdef LOGIC_PLL_LOCK_SERVICE_TIMER_PRESCALER_EN
   localparam int PRE = 4;
`else
   localparam int PRE = 1;
`endif

   logic aclk;
   logic areset_n;
   int   total = 0;
   int   bad   = 0;

   logic_axi4_stream_if #(.TDATA_BYTES(4)) cfg_if ();
   logic_axi4_stream_if #(.TDATA_BYTES(4)) tmr_if ();

   logic_pll_lock_service_timer #(.TDATA_BYTES(4), .PRESCALER(PRE)) dut (
      .aclk         (aclk),
      .areset_n     (areset_n),
      .timer_config (cfg_if.rx),
      .timer        (tmr_if.tx)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   typedef struct {
      logic [31:0] n;
      int          lat;
   } vec_t;

   vec_t vecs [6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   task automatic do_load(input logic [31:0] n);
      cfg_if.tvalid = 1'b1;
      cfg_if.tdata  = n;
      cfg_if.tlast  = $urandom_range(0, 1);
      cfg_if.tuser  = $urandom_range(0, 1);
      step();
      cfg_if.tvalid = 1'b0;
      cfg_if.tdata  = $urandom;
   endtask

   // Cycles after the load edge until tvalid is seen; -1 if the bound expires.
   task automatic wait_valid(input int limit, output int lat);
      lat = 1;
      step();
      while (!tmr_if.tvalid && lat < limit) begin
         step();
         lat++;
      end
      if (!tmr_if.tvalid) lat = -1;
   endtask

   initial begin
      int lat;
      int errs;
      int events;
      int first;

      vecs[0] = '{32'd5, 5};
      vecs[1] = '{32'd0, 1};
      vecs[2] = '{32'd1, 1};
      vecs[3] = '{32'd2, 2};
      vecs[4] = '{32'd7, 7};
      vecs[5] = '{32'd3, 3};

      areset_n      = 1'b0;
      cfg_if.tvalid = 1'b0;
      cfg_if.tdata  = '0;
      cfg_if.tstrb  = '1;
      cfg_if.tkeep  = '1;
      cfg_if.tlast  = 1'b0;
      cfg_if.tuser  = '0;
      cfg_if.tdest  = '0;
      cfg_if.tid    = '0;
      tmr_if.tready = 1'b0;

      #3;
      chk("reset_tready", cfg_if.tready, 1);
      chk("reset_tvalid", tmr_if.tvalid, 0);
      chk("reset_tdata", tmr_if.tdata, 0);
      step();
      step();
      areset_n = 1'b1;

      errs = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (tmr_if.tvalid !== 1'b0 || cfg_if.tready !== 1'b1) errs++;
      end
      chk("idle_100", errs, 0);

      // Latency table with consumer always ready.
      tmr_if.tready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         do_load(vecs[i].n);
         chk("no_valid_at_load", tmr_if.tvalid, (vecs[i].lat * PRE == 0) ? 1 : 0);
         wait_valid(vecs[i].lat * PRE + 20, lat);
         chk($sformatf("latency_n%0d", vecs[i].n), lat, vecs[i].lat * PRE);
         chk("evt_tdata", tmr_if.tdata, vecs[i].n);
         chk("evt_tlast", tmr_if.tlast, 1);
         chk("evt_tkeep", {tmr_if.tstrb, tmr_if.tkeep}, 8'hFF);
         chk("evt_side", {tmr_if.tuser, tmr_if.tdest, tmr_if.tid}, 0);
         step();
         chk("evt_one_cycle", tmr_if.tvalid, 0);
      end

      // Backpressure: event held with stable data until accepted.
      tmr_if.tready = 1'b0;
      do_load(32'd3);
      wait_valid(3 * PRE + 20, lat);
      chk("bp_latency", lat, 3 * PRE);
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (!(tmr_if.tvalid === 1'b1 && tmr_if.tdata === 32'd3)) errs++;
      end
      chk("bp_hold", errs, 0);
      tmr_if.tready = 1'b1;
      step();
      chk("bp_drop", tmr_if.tvalid, 0);
      errs = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (tmr_if.tvalid !== 1'b0) errs++;
      end
      chk("bp_idle_after", errs, 0);

      // Reload while running: only the new period produces an event.
      do_load(32'd10);
      for (int i = 0; i < 3; i++) step();
      do_load(32'd2);
      events = 0;
      first  = -1;
      for (int i = 1; i <= 15 * PRE + 10; i++) begin
         step();
         if (tmr_if.tvalid) begin
            events++;
            if (first < 0) first = i;
         end
      end
      chk("reload_events", events, 1);
      chk("reload_latency", first, 2 * PRE);

      // Reset in mid-count of the largest period.
      do_load(32'hFFFF_FFFF);
      for (int i = 0; i < 20; i++) step();
      areset_n = 1'b0;
      #1;
      chk("rst_count_tvalid", tmr_if.tvalid, 0);
      step();
      areset_n = 1'b1;
      errs = 0;
      for (int i = 0; i < 40; i++) begin
         step();
         if (tmr_if.tvalid !== 1'b0) errs++;
      end
      chk("rst_count_quiet", errs, 0);

      // Reset while the event is pending.
      tmr_if.tready = 1'b0;
      do_load(32'd1);
      wait_valid(PRE + 20, lat);
      chk("rst_evt_pending", tmr_if.tvalid, 1);
      areset_n = 1'b0;
      #1;
      chk("rst_evt_tvalid", tmr_if.tvalid, 0);
      chk("rst_evt_tdata", tmr_if.tdata, 0);
      step();
      areset_n = 1'b1;
      tmr_if.tready = 1'b1;
      errs = 0;
      for (int i = 0; i < 30; i++) begin
         step();
         if (tmr_if.tvalid !== 1'b0) errs++;
      end
      chk("rst_evt_quiet", errs, 0);

      // Load in EXPIRED with tready=1 in the same cycle: the load wins.
      tmr_if.tready = 1'b0;
      do_load(32'd4);
      wait_valid(4 * PRE + 20, lat);
      chk("exp_latency", lat, 4 * PRE);
      tmr_if.tready = 1'b1;
      do_load(32'd2);
      chk("exp_load_drop", tmr_if.tvalid, (2 * PRE == 0) ? 1 : 0);
      lat = 1;
      while (!tmr_if.tvalid && lat < 2 * PRE + 20) begin
         step();
         lat++;
      end
      if (!tmr_if.tvalid) lat = -1;
      chk("exp_reload_latency", lat, 2 * PRE + 1);
      chk("exp_reload_tdata", tmr_if.tdata, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
